// File: rtl/pcie_tx_source.sv
// pcie_tx_source
//   Per-port transmit source in front of one input port of the PCIE
//   transaction layer. Host words are buffered in two virtual-channel
//   queues (VC0, VC1). One word per cycle is arbitrated onto the link.
//   Each VC obeys the layer's pause/continue flow-control pulses.
//
// Configuration macro: PCIE_SRC_RR_EN
//   defined   : round-robin between VC0 and VC1 when both are eligible
//   undefined : strict priority, VC0 before VC1
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   wr_en        host load strobe, one word per cycle
//   wr_data      host word: [BUS_SIZE] = VC select, [BUS_SIZE-1] = dest port,
//                remaining bits = payload
//   pause_VCx    from layer: stop issuing VCx words
//   continue_VCx from layer: resume issuing VCx words
//   data_out     word to the layer's data_pN input
//   valid_out    data_out carries a valid word this cycle
//   full_VCx     VCx queue holds MEM_LENGTH words
//   overflow     one-cycle pulse: a write was dropped because its queue was full
//   idle         both queues empty and valid_out low
module pcie_tx_source #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BUS_SIZE:0] wr_data,
  input  logic              pause_VC0,
  input  logic              continue_VC0,
  input  logic              pause_VC1,
  input  logic              continue_VC1,
  output logic [BUS_SIZE:0] data_out,
  output logic              valid_out,
  output logic              full_VC0,
  output logic              full_VC1,
  output logic              overflow,
  output logic              idle
);

  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_LENGTH);

  typedef enum logic {
    FC_RUN  = 1'b0,
    FC_HALT = 1'b1
  } fc_state_e;

  logic [BUS_SIZE:0]   mem_q    [2][MEM_LENGTH];
  logic [BUS_SIZE:0]   mem_d    [2][MEM_LENGTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q [2];
  logic [ADDR_WIDTH-1:0] wr_ptr_d [2];
  logic [ADDR_WIDTH-1:0] rd_ptr_q [2];
  logic [ADDR_WIDTH-1:0] rd_ptr_d [2];
  logic [CNT_W-1:0]    count_q  [2];
  logic [CNT_W-1:0]    count_d  [2];
  fc_state_e           fc_q     [2];
  fc_state_e           fc_d     [2];

  logic [BUS_SIZE:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              idle_q, idle_d;

  logic [1:0] pause_in, cont_in, elig, do_wr, do_rd;
  logic       wr_vc;

`ifdef PCIE_SRC_RR_EN
  // 1 = VC1 was granted last, so VC0 wins the next tie.
  logic last_grant_q, last_grant_d;
`endif

  always_comb begin
    pause_in = {pause_VC1, pause_VC0};
    cont_in  = {continue_VC1, continue_VC0};
    wr_vc    = wr_data[BUS_SIZE];

    // The flow-control next state feeds this edge's arbitration, so a pause
    // sampled at an edge already blocks issue at that same edge.
    for (int v = 0; v < 2; v++) begin
      fc_d[v] = pause_in[v] ? FC_HALT : (cont_in[v] ? FC_RUN : fc_q[v]);
      elig[v] = (count_q[v] != '0) && (fc_d[v] == FC_RUN);
    end

    do_rd = 2'b00;
`ifdef PCIE_SRC_RR_EN
    last_grant_d = last_grant_q;
    if (elig == 2'b11) begin
      if (last_grant_q) do_rd[0] = 1'b1;
      else              do_rd[1] = 1'b1;
    end else begin
      do_rd = elig;
    end
    if (do_rd != 2'b00) last_grant_d = do_rd[1];
`else
    if (elig[0])      do_rd[0] = 1'b1;
    else if (elig[1]) do_rd[1] = 1'b1;
`endif

    // Fullness is judged on pre-edge counts: a same-edge pop does not make
    // room for a write into a full queue.
    do_wr[0]   = wr_en && !wr_vc && (count_q[0] != FULL_CNT);
    do_wr[1]   = wr_en &&  wr_vc && (count_q[1] != FULL_CNT);
    overflow_d = wr_en && (count_q[wr_vc] == FULL_CNT);

    mem_d = mem_q;
    for (int v = 0; v < 2; v++) begin
      if (do_wr[v]) mem_d[v][wr_ptr_q[v]] = wr_data;
      wr_ptr_d[v] = wr_ptr_q[v] + ADDR_WIDTH'(do_wr[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + ADDR_WIDTH'(do_rd[v]);
      count_d[v]  = count_q[v] + CNT_W'(do_wr[v]) - CNT_W'(do_rd[v]);
      full_d[v]   = (count_d[v] == FULL_CNT);
    end

    // Heads are read from pre-edge storage, so a word written this edge
    // cannot bypass straight to the output.
    valid_out_d = |do_rd;
    data_out_d  = data_out_q;
    if (do_rd[0])      data_out_d = mem_q[0][rd_ptr_q[0]];
    else if (do_rd[1]) data_out_d = mem_q[1][rd_ptr_q[1]];

    idle_d = (count_d[0] == '0) && (count_d[1] == '0) && !valid_out_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < MEM_LENGTH; i++) mem_q[v][i] <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        fc_q[v]     <= FC_RUN;
      end
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      full_q      <= 2'b00;
      overflow_q  <= 1'b0;
      idle_q      <= 1'b1;
`ifdef PCIE_SRC_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fc_q        <= fc_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      idle_q      <= idle_d;
`ifdef PCIE_SRC_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign full_VC0  = full_q[0];
  assign full_VC1  = full_q[1];
  assign overflow  = overflow_q;
  assign idle      = idle_q;

endmodule
